// File: rtl/seg_scan_mux.sv
// Time-multiplexed multi-digit 7-segment driver with frame-aligned, tear-free display commits.
// Optional: define SEG_DEGHOST_EN to blank dig_sel for the first output cycle of every digit slot.
module seg_scan_mux #(
  parameter int DATA_WIDTH   = 4,
  parameter int NUM_DIGITS   = 4,
  parameter int RESULT_WIDTH = 7,
  parameter int SCAN_DIV     = 1000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load,
  input  logic [NUM_DIGITS*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]            blank_mask,
  output logic [RESULT_WIDTH-1:0]          seg_out,
  output logic [NUM_DIGITS-1:0]            dig_sel,
  output logic                             frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int VAL_W = NUM_DIGITS * DATA_WIDTH;

  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [RESULT_WIDTH-1:0] SEG_OFF  = {RESULT_WIDTH{ACTIVE_LOW != 0}};
  localparam logic [NUM_DIGITS-1:0]   DIG_OFF  = {NUM_DIGITS{ACTIVE_LOW != 0}};

  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [VAL_W-1:0]        disp_q;
  logic [VAL_W-1:0]        pend_q;
  logic                    pend_v_q;
  logic [RESULT_WIDTH-1:0] seg_q;
  logic [NUM_DIGITS-1:0]   dig_q;
  logic                    frame_done_q;

  logic [RESULT_WIDTH-1:0] seg_d;
  logic [NUM_DIGITS-1:0]   dig_d;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [7:0]              glyph_ext;
  logic [DATA_WIDTH-1:0]   cur_digit;
  logic                    slot_end;
  logic                    frame_end;

  logic [DATA_WIDTH-1:0]   digit_w [NUM_DIGITS];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_w[gi] = disp_q[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Active-high gfedcba; anything beyond hex renders as a dash.
  function automatic logic [6:0] glyph(input logic [7:0] v);
    case (v)
      8'd0:    glyph = 7'b0111111;
      8'd1:    glyph = 7'b0000110;
      8'd2:    glyph = 7'b1011011;
      8'd3:    glyph = 7'b1001111;
      8'd4:    glyph = 7'b1100110;
      8'd5:    glyph = 7'b1101101;
      8'd6:    glyph = 7'b1111101;
      8'd7:    glyph = 7'b0000111;
      8'd8:    glyph = 7'b1111111;
      8'd9:    glyph = 7'b1101111;
      8'd10:   glyph = 7'b1110111;
      8'd11:   glyph = 7'b1111100;
      8'd12:   glyph = 7'b0111001;
      8'd13:   glyph = 7'b1011110;
      8'd14:   glyph = 7'b1111001;
      8'd15:   glyph = 7'b1110001;
      default: glyph = 7'b1000000;
    endcase
  endfunction

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);
  assign cur_digit = digit_w[idx_q];

  always_comb begin
    glyph_ext = {1'b0, glyph(8'(cur_digit))};
    onehot    = NUM_DIGITS'(1) << idx_q;
    if (blank_mask[idx_q]) begin
      seg_d = SEG_OFF;
    end else begin
      seg_d = (ACTIVE_LOW != 0) ? ~glyph_ext[RESULT_WIDTH-1:0] : glyph_ext[RESULT_WIDTH-1:0];
    end
    dig_d = (ACTIVE_LOW != 0) ? ~onehot : onehot;
`ifdef SEG_DEGHOST_EN
    // cnt_q==0 marks the first output cycle of the slot being presented next.
    if (cnt_q == '0) begin
      dig_d = DIG_OFF;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      seg_q        <= SEG_OFF;
      dig_q        <= DIG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q <= slot_end ? '0 : cnt_q + CNT_W'(1);
      if (slot_end) begin
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end

      if (frame_end) begin
        // A load landing on the commit edge goes straight to the display.
        if (load) begin
          disp_q <= data_in;
        end else if (pend_v_q) begin
          disp_q <= pend_q;
        end
        pend_v_q <= 1'b0;
      end else if (load) begin
        pend_q   <= data_in;
        pend_v_q <= 1'b1;
      end

      seg_q        <= seg_d;
      dig_q        <= dig_d;
      frame_done_q <= frame_end;
    end
  end

  assign seg_out    = seg_q;
  assign dig_sel    = dig_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized bench for seg_scan_mux with a cycle-count based display model and literal anchors.
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  blank_mask = '0;
  logic [6:0]  seg_out;
  logic [3:0]  dig_sel;
  logic        frame_done;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  seg_scan_mux #(
    .DATA_WIDTH(4), .NUM_DIGITS(4), .RESULT_WIDTH(7), .SCAN_DIV(4), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .blank_mask(blank_mask),
    .seg_out(seg_out), .dig_sel(dig_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: k counts active edges since reset release; slot, phase and frame follow by arithmetic.
  int          k = 0;
  logic [15:0] shown = '0;
  logic [15:0] pend = '0;
  bit          pend_v = 1'b0;
  logic [6:0]  exp_seg = '0;
  logic [3:0]  exp_dig = '0;
  logic        exp_fd = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0; shown = '0; pend_v = 1'b0;
      exp_seg = '0; exp_dig = '0; exp_fd = 1'b0;
    end else begin
      int slot;
      slot    = (k / 4) % 4;
      exp_dig = 4'(1 << slot);
`ifdef SEG_DEGHOST_EN
      if (k % 4 == 0) exp_dig = '0;
`endif
      exp_seg = blank_mask[slot] ? 7'b0 : glyph_tab[(shown >> (4 * slot)) & 16'hF];
      exp_fd  = (k % 16 == 15);
      if (k % 16 == 15) begin
        if (load) shown = data_in;
        else if (pend_v) shown = pend;
        pend_v = 1'b0;
      end else if (load) begin
        pend = data_in; pend_v = 1'b1;
      end
      k++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("seg_model", 32'(seg_out), 32'(exp_seg));
      check("dig_model", 32'(dig_sel), 32'(exp_dig));
      check("fd_model", 32'(frame_done), 32'(exp_fd));
    end
  end

  task automatic wait_frame();
    int n = 0;
    @(negedge clk);
    while (!frame_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!frame_done) check("frame_timeout", 32'(frame_done), 32'd1);
  endtask

  // Called on the frame_done cycle; samples the second cycle of each slot.
  task automatic check_digits(input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] exp_arr [4];
    exp_arr[0] = e0; exp_arr[1] = e1; exp_arr[2] = e2; exp_arr[3] = e3;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("lit_dig", 32'(dig_sel), 32'(1 << i));
      check("lit_seg", 32'(seg_out), 32'(exp_arr[i]));
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load = 1'b1; data_in = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    #1 check("rst_seg", 32'(seg_out), 32'd0);
    check("rst_dig", 32'(dig_sel), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_seg", 32'(seg_out), 32'h3F);
`ifdef SEG_DEGHOST_EN
    check("first_dig", 32'(dig_sel), 32'd0);
`else
    check("first_dig", 32'(dig_sel), 32'd1);
`endif
    repeat (40) @(negedge clk);

    // Mid-frame load only takes effect after the next commit.
    wait_frame();
    repeat (5) @(negedge clk);
    pulse_load(16'h3A0F);
    check("no_tear", 32'(seg_out), 32'h3F);
    wait_frame();
    check_digits(7'b1110001, 7'b0111111, 7'b1110111, 7'b1001111);

    // Second load in the same frame overrides the first.
    repeat (2) @(negedge clk);
    pulse_load(16'h1111);
    repeat (3) @(negedge clk);
    pulse_load(16'h2222);
    wait_frame();
    check_digits(7'b1011011, 7'b1011011, 7'b1011011, 7'b1011011);

    // Load presented on the commit edge itself.
    wait_frame();
    repeat (15) @(negedge clk);
    load = 1'b1; data_in = 16'h5555;
    @(negedge clk);
    load = 1'b0;
    check("commit_fd", 32'(frame_done), 32'd1);
    check_digits(7'b1101101, 7'b1101101, 7'b1101101, 7'b1101101);

    // Blanked digit keeps its strobe.
    blank_mask = 4'b0100;
    wait_frame();
    repeat (10) @(negedge clk);
    check("blank_dig", 32'(dig_sel), 32'b0100);
    check("blank_seg", 32'(seg_out), 32'd0);
    wait_frame();
    blank_mask = 4'b0000;

    repeat (400) begin
      @(negedge clk);
      load    = ($urandom_range(0, 7) == 0);
      data_in = 16'($urandom);
      if ($urandom_range(0, 31) == 0) blank_mask = 4'($urandom);
    end
    load = 1'b0; blank_mask = 4'b0000;
    data_in = 16'h8888;
    pulse_load(16'h8888);

    // Asynchronous reset in the middle of a slot discards the pending value.
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("async_seg", 32'(seg_out), 32'd0);
    check("async_dig", 32'(dig_sel), 32'd0);
    check("async_fd", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_seg", 32'(seg_out), 32'h3F);
    repeat (40) @(negedge clk);
    check("pend_dropped", 32'(seg_out), 32'h3F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
